multicycle_ctrl_fsm: RTL

//  Multi-cycle MIPS controller. Sequences the shared datapath (one memory, one ALU, IR, A/B/ALUOut regs) through fetch/decode/execute/mem/writeback.

---
 rtl/mips_ctrl_pkg.sv | 73 +++++++
 rtl/alu_ctrl_decode.sv | 27 ++
 rtl/multicycle_ctrl_fsm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode and funct constants, datapath mux encodings and the control bundle.
package mips_ctrl_pkg;

    // FETCH must stay at 0 so a cleared state register means "fetch".
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_I_EXEC    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // ALU_Ctrl codes; for R-type these equal the funct field.
    localparam logic [5:0] ALU_NOP = 6'h00;
    localparam logic [5:0] ALU_ADD = 6'h20;
    localparam logic [5:0] ALU_SUB = 6'h22;
    localparam logic [5:0] ALU_AND = 6'h24;
    localparam logic [5:0] ALU_OR  = 6'h25;
    localparam logic [5:0] ALU_XOR = 6'h26;
    localparam logic [5:0] ALU_NOR = 6'h27;
    localparam logic [5:0] ALU_SLT = 6'h2a;

    // ALUSrcB mux
    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PCSource mux
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // All datapath controls issued in one cycle.
    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [5:0] alu_ctrl;
        logic       halted;
    } ctrl_t;

    // States in which a memory request is outstanding.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational R-type funct decode: ALU operation plus legality flag.
// Shared with the single-cycle control_unit so both agree on the codes.
module alu_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [5:0] alu_ctrl,
    output logic       legal
);

    // Legal functs pass straight through as the ALU code; others flag illegal.
    always_comb begin
        alu_ctrl = ALU_NOP;
        legal    = 1'b0;
        case (funct)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT: begin
                alu_ctrl = funct;
                legal    = 1'b1;
            end
            default: begin
                alu_ctrl = ALU_NOP;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS controller. Walks the shared datapath through
// fetch/decode/execute/mem/writeback, waits on a variable-latency memory,
// counts retired instructions and halts in TRAP on illegal encodings or
// memory timeouts.
//
// Memory handshake: in FETCH, MEM_READ and MEM_WRITE the request
// (MemRead/MemWrite) is held every cycle until the memory raises mem_ready;
// the access completes in the cycle mem_ready is high and the FSM advances
// on that clock edge. mem_ready in any other state is ignored.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSource,
    output logic [5:0]       ALU_Ctrl,
    output logic             Halted,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       state_dbg
);

    // Wait counter only needs to reach MEM_WAIT_MAX.
    localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

    state_t             state;
    logic [5:0]         r_alu_op;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [CNT_W-1:0]   instr_count;

    logic [5:0]         dec_alu_ctrl;
    logic               dec_legal;
    logic               mem_wait;
    logic               timeout;
    logic               retire;
    ctrl_t              ctl;

    alu_ctrl_decode u_alu_ctrl_decode (
        .funct    (funct),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    // Wait/timeout detection and the per-instruction retire strobe.
    always_comb begin
        mem_wait = is_mem_state(state) && !mem_ready;
        timeout  = (MEM_WAIT_MAX != 0) && mem_wait && (wait_cnt == WAIT_LAST);
        retire   = 1'b0;
        case (state)
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEM_WRITE:                                retire = mem_ready;
            default:                                    retire = 1'b0;
        endcase
    end

    // State register, latched ALU op, wait counter and retired-instruction count.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            r_alu_op    <= ALU_NOP;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            if ((MEM_WAIT_MAX != 0) && mem_wait)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            if (retire)
                instr_count <= instr_count + CNT_W'(1);

            case (state)
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (timeout) state <= S_TRAP;
                end
                S_DECODE: begin
                    r_alu_op <= dec_alu_ctrl;
                    case (opcode)
                        OP_LW, OP_SW: state <= S_MEM_ADDR;
                        OP_RTYPE:     state <= dec_legal ? S_R_EXEC : S_TRAP;
                        OP_ADDI:      state <= S_I_EXEC;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR:
                    state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (mem_ready)    state <= S_MEM_WB;
                    else if (timeout) state <= S_TRAP;
                end
                S_MEM_WRITE: begin
                    if (mem_ready)    state <= S_FETCH;
                    else if (timeout) state <= S_TRAP;
                end
                S_R_EXEC: state <= S_R_WB;
                S_I_EXEC: state <= S_I_WB;
                S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                    state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_TRAP;
            endcase
        end
    end

    // Control outputs decoded from the state register; all forced low in reset.
    always_comb begin
        ctl = '0;
        case (state)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.iord      = 1'b0;
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_FOUR;
                ctl.alu_ctrl  = ALU_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctl.alu_src_a = 1'b0;
                ctl.alu_src_b = SRCB_IMM_SH;
                ctl.alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADDR, S_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_ctrl  = ALU_ADD;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_ctrl  = r_alu_op;
            end
            S_R_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b1;
                ctl.mem_to_reg = 1'b0;
            end
            S_I_WB: begin
                ctl.reg_write  = 1'b1;
                ctl.reg_dst    = 1'b0;
                ctl.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_ctrl  = ALU_SUB;
                ctl.pc_source = PCSRC_ALUOUT;
                ctl.pc_write  = zero;
            end
            S_JUMP: begin
                ctl.pc_source = PCSRC_JUMP;
                ctl.pc_write  = 1'b1;
            end
            S_TRAP: begin
                ctl.halted = 1'b1;
            end
            default: ctl = '0;
        endcase
        if (reset)
            ctl = '0;
    end

    assign PCWrite    = ctl.pc_write;
    assign IorD       = ctl.iord;
    assign MemRead    = ctl.mem_read;
    assign MemWrite   = ctl.mem_write;
    assign IRWrite    = ctl.ir_write;
    assign RegDst     = ctl.reg_dst;
    assign MemToReg   = ctl.mem_to_reg;
    assign RegWrite   = ctl.reg_write;
    assign ALUSrcA    = ctl.alu_src_a;
    assign ALUSrcB    = ctl.alu_src_b;
    assign PCSource   = ctl.pc_source;
    assign ALU_Ctrl   = ctl.alu_ctrl;
    assign Halted     = ctl.halted;
    assign InstrCount = instr_count;
    assign state_dbg  = state;

endmodule
